reg_pipe: RTL

REG_PIPE -- requirements
Module: reg_pipe

---
 rtl/reg_pipe.sv | 70 +++++++
 1 files changed

// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage valid/ready register pipeline with bubble collapse,
// synchronous flush and an asynchronous active-high clear.
module reg_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           clearb,
  input  logic [WIDTH-1:0]               d,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           flush,
  output logic [WIDTH-1:0]               q,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic             adv_acc;
  logic             accept;
  logic             take;

  // Advance terms: a stage moves if it is empty or everything ahead of it moves.
  always_comb begin
    adv     = '0;
    adv_acc = ~v[DEPTH-1] | out_ready;
    adv[DEPTH-1] = adv_acc;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      adv_acc = ~v[i] | adv_acc;
      adv[i]  = adv_acc;
    end
  end

  assign in_ready  = adv[0];
  assign accept    = in_valid & in_ready;
  assign take      = out_valid & out_ready;
  assign q         = data[DEPTH-1];
  assign out_valid = v[DEPTH-1];

  // Stage registers and occupancy count; clear and flush wipe everything.
  always_ff @(posedge clock or posedge clearb) begin
    if (clearb) begin
      v     <= '0;
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) data[i] <= '0;
    end else if (flush) begin
      v     <= '0;
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) data[i] <= '0;
    end else begin
      if (adv[0]) begin
        data[0] <= d;
        v[0]    <= in_valid;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (adv[i]) begin
          data[i] <= data[i-1];
          v[i]    <= v[i-1];
        end
      end
      count <= count + CW'(accept) - CW'(take);
    end
  end

endmodule
